// File: rtl/ef_spi_slave_responder.sv
// SPI slave responder: oversampled SPI pins, MOSI bytes out on a
// valid/ready stream, MISO bytes from a one-deep TX holding register.
//
// Ports:
//   clk_i, rst_i          system clock, async active-high reset
//   sclk, csb, mosi       SPI pins from the master (asynchronous)
//   miso                  SPI data to the master
//   tx_data/valid/ready   byte to send (ready = holding reg empty)
//   rx_data/valid/ready   received byte stream
//   frame_active          frame in progress
//   overrun, underrun     pulses: RX byte dropped / 0xFF sent
// Build option: EF_SPI_SLAVE_RX_FIFO_EN selects a FIFO_DEPTH-entry
// RX FIFO instead of the single RX register.

module ef_spi_slave_responder #(
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter int   FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk,
  input  logic       csb,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_active,
  output logic       overrun,
  output logic       underrun
);

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic SAMPLE_RISE = ~(CPOL ^ CPHA);

  state_t      state;
  state_t      state_n;
  logic [2:0]  sclk_q;
  logic [2:0]  csb_q;
  logic [1:0]  mosi_q;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        csb_rise;
  logic        csb_fall;
  logic        sample_edge;
  logic        launch_edge;
  logic        enter;
  logic        leave;
  logic        act;
  logic        smp;
  logic        lch;
  logic        load;
  logic        tx_wr;
  logic        byte_done;
  logic        skip;
  logic        hold_full;
  logic        miso_q;
  logic [2:0]  bit_cnt;
  logic [7:0]  hold_data;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;

  // csb flops reset low so a csb already low at reset
  // release never shows up as a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q <= {3{CPOL}};
      csb_q  <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      csb_q  <= {csb_q[1:0], csb};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign csb_rise  = csb_q[1] & ~csb_q[2];
  assign csb_fall  = ~csb_q[1] & csb_q[2];

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign launch_edge = SAMPLE_RISE ? sclk_fall : sclk_rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (csb_fall) state_n = ACTIVE;
      ACTIVE: if (csb_rise) state_n = IDLE;
    endcase
  end

  assign enter = (state == IDLE) && csb_fall;
  assign leave = (state == ACTIVE) && csb_rise;
  assign act   = (state == ACTIVE) && !csb_rise;
  assign smp   = act && sample_edge;
  assign lch   = act && launch_edge;
  assign load  = enter || (act && byte_done);
  assign tx_wr = tx_valid && tx_ready;

  assign tx_ready     = ~hold_full;
  assign frame_active = (state == ACTIVE);
  assign miso         = miso_q;

  // skip: the next launch edge keeps the freshly loaded MSB.
  // CPHA=1 needs it on every load; CPHA=0 only between bytes,
  // where the trailing edge after the 8th sample follows a load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      skip      <= 1'b0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'hFF;
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      miso_q    <= 1'b1;
      underrun  <= 1'b0;
    end else begin
      underrun  <= 1'b0;
      byte_done <= smp && (bit_cnt == 3'd7);
      if (smp) begin
        rx_shift <= {rx_shift[6:0], mosi_q[1]};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (leave) begin
        bit_cnt <= 3'd0;
        skip    <= 1'b0;
      end
      if (lch) begin
        if (skip) skip <= 1'b0;
        else tx_shift <= {tx_shift[6:0], 1'b1};
      end
      if (load) begin
        tx_shift <= hold_full ? hold_data : 8'hFF;
        underrun <= ~hold_full;
        skip     <= CPHA | ~enter;
      end
      if (load) hold_full <= 1'b0;
      if (tx_wr) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end
      miso_q <= (state == ACTIVE) ? tx_shift[7] : 1'b1;
    end
  end

`ifdef EF_SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign full     = (cnt == (AW+1)'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = byte_done && (!full || pop);
  assign rx_valid = (cnt != '0);
  assign rx_data  = mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      overrun <= byte_done && full && !pop;
      if (push_ok) begin
        mem[wptr] <= rx_shift;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ef_spi_slave_responder.sv
// Bench for ef_spi_slave_responder: mode 0 and mode 3 instances
// driven by a behavioural SPI master, checked against a byte model.

module tb_ef_spi_slave_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sclk_p [2];
  logic       csb_p [2];
  logic       mosi_p [2];
  logic       miso_p [2];
  logic [7:0] tx_data_p [2];
  logic       tx_valid_p [2];
  logic       tx_ready_p [2];
  logic [7:0] rx_data_p [2];
  logic       rx_valid_p [2];
  logic       rx_ready_p [2];
  logic       frame_p [2];
  logic       ovr_p [2];
  logic       und_p [2];

  ef_spi_slave_responder #(
    .CPOL(1'b0), .CPHA(1'b0), .FIFO_DEPTH(4)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .sclk(sclk_p[0]), .csb(csb_p[0]),
    .mosi(mosi_p[0]), .miso(miso_p[0]),
    .tx_data(tx_data_p[0]), .tx_valid(tx_valid_p[0]),
    .tx_ready(tx_ready_p[0]),
    .rx_data(rx_data_p[0]), .rx_valid(rx_valid_p[0]),
    .rx_ready(rx_ready_p[0]),
    .frame_active(frame_p[0]),
    .overrun(ovr_p[0]), .underrun(und_p[0])
  );

  ef_spi_slave_responder #(
    .CPOL(1'b1), .CPHA(1'b1), .FIFO_DEPTH(4)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .sclk(sclk_p[1]), .csb(csb_p[1]),
    .mosi(mosi_p[1]), .miso(miso_p[1]),
    .tx_data(tx_data_p[1]), .tx_valid(tx_valid_p[1]),
    .tx_ready(tx_ready_p[1]),
    .rx_data(rx_data_p[1]), .rx_valid(rx_valid_p[1]),
    .rx_ready(rx_ready_p[1]),
    .frame_active(frame_p[1]),
    .overrun(ovr_p[1]), .underrun(und_p[1])
  );

  int pass_cnt = 0;
  int total = 0;
  int und_cnt [2] = '{0, 0};
  int ovr_cnt [2] = '{0, 0};
  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];

  always @(posedge clk) begin
    if (!rst) begin
      if (und_p[0]) und_cnt[0] <= und_cnt[0] + 1;
      if (und_p[1]) und_cnt[1] <= und_cnt[1] + 1;
      if (ovr_p[0]) ovr_cnt[0] <= ovr_cnt[0] + 1;
      if (ovr_p[1]) ovr_cnt[1] <= ovr_cnt[1] + 1;
      if (rx_valid_p[0] && rx_ready_p[0])
        rxq0.push_back(rx_data_p[0]);
      if (rx_valid_p[1] && rx_ready_p[1])
        rxq1.push_back(rx_data_p[1]);
    end
  end

  // master-side frame description
  logic [7:0] m_tx [8];
  logic [7:0] m_rx [8];
  logic [7:0] s_tx [8];
  bit         s_have [8];
  int         und_start;
  int         und_win;

  typedef struct {
    int         k;
    logic [7:0] mb;
    logic [7:0] tb;
    bit         have;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vt [10];

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk8(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h",
                  nm, act, exp);
  endtask

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b",
                  nm, act, exp);
  endtask

  // expected MISO byte: the queued byte, or 0xFF if none
  function automatic logic [7:0] ref_miso(input bit have,
                                          input logic [7:0] d);
    return have ? d : 8'hFF;
  endfunction

  function automatic int qsize(input int k);
    return (k == 1) ? rxq1.size() : rxq0.size();
  endfunction

  function automatic logic [7:0] qget(input int k, input int i);
    if (i >= qsize(k)) return 8'hxx;
    return (k == 1) ? rxq1[i] : rxq0[i];
  endfunction

  task automatic push_tx(input int k, input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready_p[k] && t < 20) begin
      wclk(1);
      t++;
    end
    if (!tx_ready_p[k]) begin
      total++;
      $display("FAIL tx_ready_timeout dut%0d: got 0 expected 1", k);
    end
    tx_data_p[k]  = d;
    tx_valid_p[k] = 1'b1;
    wclk(1);
    tx_valid_p[k] = 1'b0;
  endtask

  task automatic pop(input int k);
    rx_ready_p[k] = 1'b1;
    wclk(1);
    rx_ready_p[k] = 1'b0;
  endtask

  // SCK = clk/8; k=0 is mode 0, k=1 is mode 3
  task automatic frame(input int k, input int nb,
                       input int lastbits);
    bit cp;
    int lo;
    cp = (k == 1);
    if (s_have[0]) push_tx(k, s_tx[0]);
    und_start = und_cnt[k];
    mosi_p[k] = m_tx[0][7];
    csb_p[k] = 1'b0;
    wclk(6);
    for (int j = 0; j < nb; j++) begin
      lo = (j == nb - 1) ? 8 - lastbits : 0;
      for (int b = 7; b >= lo; b--) begin
        if (!cp) begin
          mosi_p[k] = m_tx[j][b];
          wclk(4);
          sclk_p[k] = 1'b1;
        end else begin
          sclk_p[k] = 1'b0;
          mosi_p[k] = m_tx[j][b];
          wclk(4);
          sclk_p[k] = 1'b1;
        end
        m_rx[j][b] = miso_p[k];
        if (j == nb - 1 && b == lo)
          und_win = und_cnt[k] - und_start;
        wclk(4);
        if (!cp) sclk_p[k] = 1'b0;
        if (b == 4 && j + 1 < nb && s_have[j + 1])
          push_tx(k, s_tx[j + 1]);
      end
    end
    wclk(3);
    csb_p[k] = 1'b1;
    wclk(10);
  endtask

  task automatic chk_reset(input int k);
    chk1("rst_miso", miso_p[k], 1'b1);
    chk1("rst_tx_ready", tx_ready_p[k], 1'b1);
    chk1("rst_rx_valid", rx_valid_p[k], 1'b0);
    chk8("rst_rx_data", rx_data_p[k], 8'h00);
    chk1("rst_frame", frame_p[k], 1'b0);
    chk1("rst_overrun", ovr_p[k], 1'b0);
    chk1("rst_underrun", und_p[k], 1'b0);
  endtask

  initial begin
    int k;
    int n;
    int base;
    int exp_u;
    int ovr_start;

    for (int i = 0; i < 2; i++) begin
      sclk_p[i] = (i == 1);
      csb_p[i] = 1'b1;
      mosi_p[i] = 1'b0;
      tx_data_p[i] = 8'h00;
      tx_valid_p[i] = 1'b0;
      rx_ready_p[i] = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      s_have[j] = 0;
      s_tx[j] = 8'h00;
      m_tx[j] = 8'h00;
      m_rx[j] = 8'h00;
    end
    wclk(3);
    rst = 1'b0;
    wclk(2);
    chk_reset(0);
    chk_reset(1);

    vt[0] = '{0, 8'h3C, 8'hA5, 1, 8'hA5, 8'h3C, 0};
    vt[1] = '{1, 8'h69, 8'h96, 1, 8'h96, 8'h69, 0};
    vt[2] = '{0, 8'h00, 8'h00, 0, 8'hFF, 8'h00, 1};
    vt[3] = '{1, 8'hFF, 8'h00, 1, 8'h00, 8'hFF, 0};
    for (int i = 4; i < 10; i++) begin
      vt[i].k = i % 2;
      vt[i].mb = 8'($urandom);
      vt[i].tb = 8'($urandom);
      vt[i].have = 1'($urandom_range(0, 1));
      vt[i].exp_miso = ref_miso(vt[i].have, vt[i].tb);
      vt[i].exp_rx = vt[i].mb;
      vt[i].exp_und = vt[i].have ? 0 : 1;
    end

    for (int i = 0; i < 10; i++) begin
      k = vt[i].k;
      m_tx[0] = vt[i].mb;
      s_tx[0] = vt[i].tb;
      s_have[0] = vt[i].have;
      frame(k, 1, 8);
      chk8("vec_miso", m_rx[0], vt[i].exp_miso);
      chk8("vec_underrun", 8'(und_win), 8'(vt[i].exp_und));
      chk1("vec_rx_valid", rx_valid_p[k], 1'b1);
      chk8("vec_rx_data", rx_data_p[k], vt[i].exp_rx);
      pop(k);
      chk1("vec_rx_popped", rx_valid_p[k], 1'b0);
    end

    // three bytes with TX empty
    m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
    for (int j = 0; j < 3; j++) s_have[j] = 0;
    rx_ready_p[0] = 1'b1;
    base = qsize(0);
    frame(0, 3, 8);
    rx_ready_p[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk8("three_miso", m_rx[j], 8'hFF);
      chk8("three_rx", qget(0, base + j), m_tx[j]);
    end
    chk8("three_underrun", 8'(und_win), 8'd3);

    // randomized multi-byte frames against the byte model
    for (int r = 0; r < 6; r++) begin
      k = r % 2;
      n = $urandom_range(2, 4);
      for (int j = 0; j < n; j++) begin
        m_tx[j] = 8'($urandom);
        s_tx[j] = 8'($urandom);
        s_have[j] = 1'($urandom_range(0, 1));
      end
      rx_ready_p[k] = 1'b1;
      base = qsize(k);
      frame(k, n, 8);
      rx_ready_p[k] = 1'b0;
      exp_u = 0;
      for (int j = 0; j < n; j++) begin
        chk8("rnd_miso", m_rx[j], ref_miso(s_have[j], s_tx[j]));
        chk8("rnd_rx", qget(k, base + j), m_tx[j]);
        if (!s_have[j]) exp_u++;
      end
      chk8("rnd_underrun", 8'(und_win), 8'(exp_u));
      chk8("rnd_rx_count", 8'(qsize(k) - base), 8'(n));
    end
    for (int j = 0; j < 8; j++) s_have[j] = 0;

    // RX overflow with the consumer stalled
    ovr_start = ovr_cnt[0];
`ifdef EF_SPI_SLAVE_RX_FIFO_EN
    for (int j = 0; j < 5; j++) m_tx[j] = 8'(j + 1);
    frame(0, 5, 8);
    chk8("fifo_overrun", 8'(ovr_cnt[0] - ovr_start), 8'd1);
    for (int j = 0; j < 4; j++) begin
      chk1("fifo_valid", rx_valid_p[0], 1'b1);
      chk8("fifo_data", rx_data_p[0], 8'(j + 1));
      pop(0);
    end
    chk1("fifo_empty", rx_valid_p[0], 1'b0);
`else
    m_tx[0] = 8'hAA; m_tx[1] = 8'h55;
    frame(0, 2, 8);
    chk8("reg_overrun", 8'(ovr_cnt[0] - ovr_start), 8'd1);
    chk1("reg_valid", rx_valid_p[0], 1'b1);
    chk8("reg_data_kept", rx_data_p[0], 8'hAA);
    pop(0);
    chk1("reg_empty", rx_valid_p[0], 1'b0);
`endif

    // abort after 5 bits, then a clean frame
    m_tx[0] = 8'hFF;
    frame(0, 1, 5);
    chk1("abort_no_push", rx_valid_p[0], 1'b0);
    m_tx[0] = 8'hC3;
    frame(0, 1, 8);
    chk1("after_abort_valid", rx_valid_p[0], 1'b1);
    chk8("after_abort_data", rx_data_p[0], 8'hC3);
    pop(0);

    // reset in the middle of a mode 3 frame
    m_tx[0] = 8'h3A;
    frame(1, 1, 8);
    csb_p[1] = 1'b0;
    wclk(6);
    push_tx(1, 8'h5A);
    sclk_p[1] = 1'b0;
    wclk(4);
    sclk_p[1] = 1'b1;
    wclk(2);
    chk1("mid_frame_active", frame_p[1], 1'b1);
    chk1("mid_tx_full", tx_ready_p[1], 1'b0);
    chk1("mid_rx_valid", rx_valid_p[1], 1'b1);
    rst = 1'b1;
    #1;
    chk_reset(1);
    chk_reset(0);
    wclk(2);
    rst = 1'b0;
    wclk(6);
    chk1("low_csb_no_frame", frame_p[1], 1'b0);
    for (int e = 0; e < 4; e++) begin
      sclk_p[1] = ~sclk_p[1];
      wclk(4);
    end
    chk1("post_rst_frame", frame_p[1], 1'b0);
    chk1("post_rst_miso", miso_p[1], 1'b1);
    chk1("post_rst_rx", rx_valid_p[1], 1'b0);
    sclk_p[1] = 1'b1;
    csb_p[1] = 1'b1;
    wclk(8);
    m_tx[0] = 8'h5C;
    s_tx[0] = 8'h7E;
    s_have[0] = 1;
    frame(1, 1, 8);
    chk8("recover_miso", m_rx[0], 8'h7E);
    chk8("recover_rx", rx_data_p[1], 8'h5C);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
